modp_share_engine: RTL and testbench
====================================

Name: modp_share_engine

Overview:
- Parametrised successor to the fixed 40-bit cryptoprocessor wrapper: a register file of two-share operands, where the value is (s1 + s2) mod P.
- Carries a modular ALU supporting LOAD, COPY, ADD, SUB, READ and bit-serial Montgomery MUL.
- Adds a valid/ready command handshake, a registered response channel, an error flag and a multi-cycle multiplier stall.
- Sits between the isogeny VDF sequencer and the field-arithmetic datapath.

Parameters:
- W, 40, share and modulus width in bits; P must satisfy 2^(W-1) < P < 2^W.
- ADDR_W, 7, register-address field width.
- DEPTH, 128, number of implemented entries; DEPTH <= 2^ADDR_W.
- P, 574448099311, field modulus.
- MONT_K, W, Montgomery exponent; R = 2^MONT_K; MUL returns a*b*R^-1 mod P.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command this cycle
- cmd  in  3+3*ADDR_W  {op[3], srcA[ADDR_W], srcB[ADDR_W], dst[ADDR_W]}, op in the MSBs
- din_1  in  W  share 1 for LOAD
- din_2  in  W  share 2 for LOAD
- rsp_valid  out  1  dout pair valid (one-cycle pulse)
- dout_1  out  W  READ share 1
- dout_2  out  W  READ share 2
- busy  out  1  MUL in progress
- err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset:
  - rst clears all DEPTH entries to (0,0), aborts any MUL without writing, and returns the FSM to IDLE.
  - Output reset values: cmd_ready=1, busy=0, rsp_valid=0, err=0, dout_1=dout_2=0.
- Accept: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_valid while cmd_ready=0 is ignored; it is not queued.
- Opcodes:
  - 0 NOP: no effect.
  - 1 LOAD: rf[dst] <= (din_1, din_2), stored raw and unreduced.
  - 2 COPY: rf[dst] <= rf[srcA].
  - 3 ADD: rf[dst] <= ((A+B) mod P, 0).
  - 4 SUB: rf[dst] <= ((A-B) mod P, 0).
  - 5 MUL: rf[dst] <= (A*B*R^-1 mod P, 0).
  - 6 READ: (dout_1, dout_2) <= rf[srcA], raw shares.
  - 7 reserved.
  - A = (srcA.s1 + srcA.s2) mod P; B is formed the same way from srcB.
- Operand reduction: share sum < 2^(W+1) < 4P. Conditionally subtract 2P, then conditionally subtract P, giving a canonical value in [0, P).
- Single-cycle ops (NOP, LOAD, COPY, ADD, SUB, READ):
  - The register file is read combinationally from the cmd fields; the result is written on the accepting edge.
  - cmd_ready stays 1, so back-to-back commands are accepted and the next command sees the written value without forwarding.
  - dst == srcA/srcB reads the old value.
- READ response: dout is registered on the accepting edge, so rsp_valid=1 in the following cycle only. dout holds its last value when rsp_valid=0.
- MUL FSM, states IDLE -> MUL -> FIN -> IDLE:
  - Accepting edge: latch canonical A and B, set T=0, i=0, busy=1, cmd_ready=0.
  - MUL state, one bit per cycle for MONT_K cycles: T = T + A[i]*B; if T is odd, T = T + P; T = T >> 1. T width is W+2.
  - FIN state, one cycle: if T >= P then T = T - P; write rf[dst] = (T, 0); busy=0 and cmd_ready=1 from the next cycle.
  - Total: cmd_ready is low for MONT_K+1 cycles; the result is visible to a command accepted on the edge after FIN.
- Errors: op 7, or any used address field >= DEPTH, produces an err pulse one cycle after acceptance, with no register-file or dout change. Used fields are: dst for LOAD, COPY, ADD, SUB, MUL; srcA for COPY, READ, ADD, SUB, MUL; srcB for ADD, SUB, MUL.
- Simultaneous events: rst has priority over everything. err and rsp_valid never assert together.

Test Plan:
- Load/read: LOAD dst0 with (5,7); READ srcA=0 -> the cycle after acceptance, rsp_valid=1, dout=(5,7); rsp_valid=0 the cycle after that.
- ADD wrap: LOAD r0=(P-1,0), r1=(1,1); ADD r3=r0+r1 -> READ r3 gives (1,0). Issue back-to-back with no idle cycles; cmd_ready stays 1 throughout.
- SUB borrow and share reduction:
  - SUB r4=r1-r0 with r1=(1,1), r0=(P-1,0) -> READ gives (3,0).
  - LOAD r5=(2^40-1, 2^40-1); COPY r6=r5 -> READ r6 gives the raw shares unchanged.
  - ADD r7=r5+r1 -> READ r7 gives ((2^41-2+2) mod P, 0).
- Montgomery MUL:
  - LOAD r0=(525063528465,0), which is R mod P; LOAD r1=(7,0); MUL r2=r0*r1.
  - cmd_ready=0 and busy=1 for exactly 41 cycles; a cmd_valid held during the stall is not accepted.
  - READ r2 gives (7,0).
- Errors: op 7 -> err pulse, no state change. With DEPTH=100, LOAD dst=100 -> err pulse, and READ of r100's alias entries is unchanged.
- Reset mid-MUL: assert rst 10 cycles into a MUL -> no write; next cycle cmd_ready=1 and busy=0; READ of any entry gives (0,0).

Source files
------------

// File: rtl/modp_share_engine.sv
`default_nettype none
// ============================================================================
//  Module   : modp_share_engine
//  Purpose  : Two-share mod-P register file with a modular ALU and a
//             bit-serial Montgomery multiplier behind a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module modp_share_engine #(
   parameter int             W      = 40,
   parameter int             ADDR_W = 7,
   parameter int             DEPTH  = 128,
   parameter logic [W-1:0]   P      = W'(64'd574448099311),
   parameter int             MONT_K = W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3+3*ADDR_W-1:0] cmd,
   input  logic [W-1:0]          din_1,
   input  logic [W-1:0]          din_2,
   output logic                  rsp_valid,
   output logic [W-1:0]          dout_1,
   output logic [W-1:0]          dout_2,
   output logic                  busy,
   output logic                  err
);

   localparam logic [2:0]        c_OP_LOAD = 3'd1;
   localparam logic [2:0]        c_OP_COPY = 3'd2;
   localparam logic [2:0]        c_OP_ADD  = 3'd3;
   localparam logic [2:0]        c_OP_SUB  = 3'd4;
   localparam logic [2:0]        c_OP_MUL  = 3'd5;
   localparam logic [2:0]        c_OP_READ = 3'd6;
   localparam logic [2:0]        c_OP_RSVD = 3'd7;
   localparam logic [W+1:0]      c_PX      = {2'b00, P};
   localparam logic [W+1:0]      c_P2      = {1'b0, P, 1'b0};
   localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam int                c_CNT_W   = $clog2(MONT_K + 1);
   localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(MONT_K - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2} state_t;

   // Share sum is below 4P, so two conditional subtractions canonicalise it.
   function automatic logic [W-1:0] f_reduce(input logic [W-1:0] s1, input logic [W-1:0] s2);
      logic [W+1:0] v;
      v = {2'b00, s1} + {2'b00, s2};
      if (v >= c_P2) v = v - c_P2;
      if (v >= c_PX) v = v - c_PX;
      return W'(v);
   endfunction

   logic [W-1:0]        r_rf_s1 [DEPTH];
   logic [W-1:0]        r_rf_s2 [DEPTH];
   state_t              r_state;
   logic                r_ready, r_busy, r_rsp, r_err;
   logic [W-1:0]        r_dout_1, r_dout_2;
   logic [W+1:0]        r_t;
   logic [W-1:0]        r_a, r_b;
   logic [ADDR_W-1:0]   r_dst;
   logic [c_CNT_W-1:0]  r_cnt;

   logic [2:0]          w_op;
   logic [ADDR_W-1:0]   w_srca, w_srcb, w_dst, w_a_idx, w_b_idx;
   logic                w_a_ok, w_b_ok, w_dst_ok, w_use_a, w_use_b, w_use_dst;
   logic                w_illegal, w_accept;
   logic [W-1:0]        w_a, w_b, w_add, w_sub, w_t_fin;
   logic [W:0]          w_sum;
   logic [W+1:0]        w_t_acc, w_t_odd;

   assign w_op      = cmd[3+3*ADDR_W-1 -: 3];
   assign w_srca    = cmd[3*ADDR_W-1 -: ADDR_W];
   assign w_srcb    = cmd[2*ADDR_W-1 -: ADDR_W];
   assign w_dst     = cmd[ADDR_W-1:0];
   assign w_a_ok    = ({1'b0, w_srca} < c_DEPTH);
   assign w_b_ok    = ({1'b0, w_srcb} < c_DEPTH);
   assign w_dst_ok  = ({1'b0, w_dst}  < c_DEPTH);
   assign w_a_idx   = w_a_ok ? w_srca : '0;
   assign w_b_idx   = w_b_ok ? w_srcb : '0;
   assign w_use_dst = (w_op >= c_OP_LOAD) && (w_op <= c_OP_MUL);
   assign w_use_a   = (w_op >= c_OP_COPY) && (w_op <= c_OP_READ);
   assign w_use_b   = (w_op >= c_OP_ADD)  && (w_op <= c_OP_MUL);
   assign w_illegal = (w_op == c_OP_RSVD) || (w_use_dst && !w_dst_ok)
                   || (w_use_a && !w_a_ok) || (w_use_b && !w_b_ok);
   assign w_accept  = cmd_valid && r_ready;

   assign w_a   = f_reduce(r_rf_s1[w_a_idx], r_rf_s2[w_a_idx]);
   assign w_b   = f_reduce(r_rf_s1[w_b_idx], r_rf_s2[w_b_idx]);
   assign w_sum = {1'b0, w_a} + {1'b0, w_b};
   assign w_add = (w_sum >= {1'b0, P}) ? W'(w_sum - {1'b0, P}) : W'(w_sum);
   assign w_sub = (w_a >= w_b) ? (w_a - w_b) : W'({1'b0, w_a} + {1'b0, P} - {1'b0, w_b});

   // T stays below 2P, so T + B + P fits in W+2 bits.
   assign w_t_acc = r_t + (r_a[0] ? {2'b00, r_b} : '0);
   assign w_t_odd = w_t_acc + (w_t_acc[0] ? c_PX : '0);
   assign w_t_fin = (r_t >= c_PX) ? W'(r_t - c_PX) : W'(r_t);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_rf_s1[k] <= '0;
            r_rf_s2[k] <= '0;
         end
         r_state  <= S_IDLE;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_rsp    <= 1'b0;
         r_err    <= 1'b0;
         r_dout_1 <= '0;
         r_dout_2 <= '0;
         r_t      <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_dst    <= '0;
         r_cnt    <= '0;
      end else begin
         r_rsp <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_illegal) begin
                     r_err <= 1'b1;
                  end else begin
                     case (w_op)
                        c_OP_LOAD: begin
                           r_rf_s1[w_dst] <= din_1;
                           r_rf_s2[w_dst] <= din_2;
                        end
                        c_OP_COPY: begin
                           r_rf_s1[w_dst] <= r_rf_s1[w_a_idx];
                           r_rf_s2[w_dst] <= r_rf_s2[w_a_idx];
                        end
                        c_OP_ADD: begin
                           r_rf_s1[w_dst] <= w_add;
                           r_rf_s2[w_dst] <= '0;
                        end
                        c_OP_SUB: begin
                           r_rf_s1[w_dst] <= w_sub;
                           r_rf_s2[w_dst] <= '0;
                        end
                        c_OP_MUL: begin
                           r_a     <= w_a;
                           r_b     <= w_b;
                           r_t     <= '0;
                           r_cnt   <= '0;
                           r_dst   <= w_dst;
                           r_busy  <= 1'b1;
                           r_ready <= 1'b0;
                           r_state <= S_MUL;
                        end
                        c_OP_READ: begin
                           r_dout_1 <= r_rf_s1[w_a_idx];
                           r_dout_2 <= r_rf_s2[w_a_idx];
                           r_rsp    <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            S_MUL: begin
               r_t   <= w_t_odd >> 1;
               r_a   <= r_a >> 1;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) r_state <= S_FIN;
            end
            S_FIN: begin
               r_rf_s1[r_dst] <= w_t_fin;
               r_rf_s2[r_dst] <= '0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign busy      = r_busy;
   assign rsp_valid = r_rsp;
   assign err       = r_err;
   assign dout_1    = r_dout_1;
   assign dout_2    = r_dout_2;

endmodule
`default_nettype wire

// File: tb/tb_modp_share_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modp_share_engine
//  Purpose  : Directed self-checking bench with a per-cycle arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_modp_share_engine;
   localparam int           W      = 40;
   localparam int           ADDR_W = 7;
   localparam int           DEPTH  = 100;
   localparam int           MONT_K = 40;
   localparam logic [W-1:0] P      = 40'd574448099311;
   localparam int           CW     = 3 + 3*ADDR_W;
   typedef logic [127:0] u128_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [CW-1:0] cmd = '0;
   logic [W-1:0]  din_1 = '0, din_2 = '0;
   logic          cmd_ready, rsp_valid, busy, err;
   logic [W-1:0]  dout_1, dout_2;

   always #5 clk = ~clk;

   modp_share_engine #(.W(W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .P(P), .MONT_K(MONT_K)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
      .din_1(din_1), .din_2(din_2), .rsp_valid(rsp_valid), .dout_1(dout_1),
      .dout_2(dout_2), .busy(busy), .err(err));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input u128_t act, input u128_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] m_s1 [DEPTH];
   logic [W-1:0] m_s2 [DEPTH];
   logic         m_ready, m_busy, m_rsp, m_err;
   logic [W-1:0] m_d1, m_d2, m_res;
   int           m_stall, m_dst;
   bit           m_init = 1'b0;

   function automatic int f_op(input logic [CW-1:0] c); return int'(c[CW-1 -: 3]); endfunction
   function automatic int f_fa(input logic [CW-1:0] c); return int'(c[3*ADDR_W-1 -: ADDR_W]); endfunction
   function automatic int f_fb(input logic [CW-1:0] c); return int'(c[2*ADDR_W-1 -: ADDR_W]); endfunction
   function automatic int f_fd(input logic [CW-1:0] c); return int'(c[ADDR_W-1:0]); endfunction

   function automatic bit f_bad(input logic [CW-1:0] c);
      int op = f_op(c);
      bit ud = (op >= 1 && op <= 5);
      bit ua = (op >= 2 && op <= 6);
      bit ub = (op >= 3 && op <= 5);
      return (op == 7) || (ud && f_fd(c) >= DEPTH) || (ua && f_fa(c) >= DEPTH)
          || (ub && f_fb(c) >= DEPTH);
   endfunction

   function automatic u128_t f_reg(input int k);
      return (u128_t'(m_s1[k]) + u128_t'(m_s2[k])) % u128_t'(P);
   endfunction

   function automatic u128_t f_pow(input u128_t base, input u128_t e);
      u128_t r = 1;
      u128_t b = base % P;
      u128_t x = e;
      while (x != 0) begin
         if (x[0]) r = (r * b) % P;
         b = (b * b) % P;
         x = x >> 1;
      end
      return r;
   endfunction

   // a*b*R^-1 mod P, with R^-1 found by Fermat inversion.
   function automatic u128_t f_mont(input u128_t a, input u128_t b);
      u128_t rm = (u128_t'(1) << MONT_K) % P;
      return (((a * b) % P) * f_pow(rm, u128_t'(P) - 2)) % P;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            m_s1[k] <= '0;
            m_s2[k] <= '0;
         end
         m_ready <= 1'b1; m_busy <= 1'b0; m_rsp <= 1'b0; m_err <= 1'b0;
         m_d1 <= '0; m_d2 <= '0; m_stall <= 0; m_init <= 1'b1;
      end else begin
         m_rsp <= 1'b0;
         m_err <= 1'b0;
         if (m_stall != 0) begin
            m_stall <= m_stall - 1;
            if (m_stall == 1) begin
               m_s1[m_dst] <= m_res; m_s2[m_dst] <= '0;
               m_ready <= 1'b1; m_busy <= 1'b0;
            end
         end else if (cmd_valid) begin
            if (f_bad(cmd)) m_err <= 1'b1;
            else case (f_op(cmd))
               1: begin m_s1[f_fd(cmd)] <= din_1; m_s2[f_fd(cmd)] <= din_2; end
               2: begin m_s1[f_fd(cmd)] <= m_s1[f_fa(cmd)]; m_s2[f_fd(cmd)] <= m_s2[f_fa(cmd)]; end
               3: begin
                  m_s1[f_fd(cmd)] <= W'((f_reg(f_fa(cmd)) + f_reg(f_fb(cmd))) % P);
                  m_s2[f_fd(cmd)] <= '0;
               end
               4: begin
                  m_s1[f_fd(cmd)] <= W'((f_reg(f_fa(cmd)) + P - f_reg(f_fb(cmd))) % P);
                  m_s2[f_fd(cmd)] <= '0;
               end
               5: begin
                  m_res <= W'(f_mont(f_reg(f_fa(cmd)), f_reg(f_fb(cmd))));
                  m_dst <= f_fd(cmd); m_stall <= MONT_K + 1;
                  m_ready <= 1'b0; m_busy <= 1'b1;
               end
               6: begin m_d1 <= m_s1[f_fa(cmd)]; m_d2 <= m_s2[f_fa(cmd)]; m_rsp <= 1'b1; end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("cmd_ready", cmd_ready, m_ready);
         chk("busy", busy, m_busy);
         chk("rsp_valid", rsp_valid, m_rsp);
         chk("err", err, m_err);
         chk("dout_1", dout_1, m_d1);
         chk("dout_2", dout_2, m_d2);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int op, input int a, input int b, input int d,
                       input logic [W-1:0] x1 = '0, input logic [W-1:0] x2 = '0);
      int guard = 0;
      cmd_valid = 1'b1;
      cmd = {3'(op), ADDR_W'(a), ADDR_W'(b), ADDR_W'(d)};
      din_1 = x1;
      din_2 = x2;
      while (cmd_ready !== 1'b1 && guard < 100) begin
         tick();
         guard++;
      end
      if (guard >= 100) begin
         n_chk++; n_fail++;
         $display("FAIL ready_wait: got cmd_ready=%b, expected 1 within 100 cycles", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic rd(input int a, input logic [W-1:0] e1, input logic [W-1:0] e2, input string name);
      send(6, a, 0, 0);
      chk({name, "_rv"}, rsp_valid, 1);
      chk({name, "_d1"}, dout_1, e1);
      chk({name, "_d2"}, dout_2, e2);
   endtask

   initial begin
      int stall_cnt, busy_cnt;
      tick(); tick();
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_dout", {dout_1, dout_2}, 0);
      rst = 1'b0;

      send(1, 0, 0, 0, 5, 7);
      rd(0, 5, 7, "load_read");
      tick();
      chk("rsp_pulse", rsp_valid, 0);
      chk("dout_hold", dout_1, 5);

      send(1, 0, 0, 0, P - 1, 0);
      send(1, 0, 0, 1, 1, 1);
      send(3, 0, 1, 3);
      chk("b2b_ready", cmd_ready, 1);
      rd(3, 1, 0, "add_wrap");
      send(4, 1, 0, 4);
      rd(4, 3, 0, "sub_borrow");
      send(1, 0, 0, 5, '1, '1);
      send(2, 5, 0, 6);
      rd(6, '1, '1, "copy_raw");
      send(3, 5, 1, 7);
      rd(7, 40'd475678957619, 0, "add_reduce");

      send(1, 0, 0, 0, 40'd525063528465, 0);
      send(1, 0, 0, 1, 7, 0);
      send(5, 0, 1, 2);
      cmd_valid = 1'b1;
      cmd = {3'd1, 7'd0, 7'd0, 7'd9};
      din_1 = 1; din_2 = 1;
      stall_cnt = 0;
      busy_cnt = 0;
      while (cmd_ready === 1'b0 && stall_cnt < 100) begin
         if (busy === 1'b1) busy_cnt++;
         tick();
         stall_cnt++;
      end
      cmd_valid = 1'b0;
      chk("mul_stall", stall_cnt, 41);
      chk("mul_busy", busy_cnt, 41);
      chk("mul_done_busy", busy, 0);
      rd(2, 7, 0, "mul_result");
      rd(9, 0, 0, "stall_ignored");

      send(1, 0, 0, 36, 11, 12);
      send(7, 0, 0, 0);
      chk("op7_err", err, 1);
      chk("op7_rsp", rsp_valid, 0);
      tick();
      chk("err_pulse", err, 0);
      send(1, 0, 0, 100, 99, 99);
      chk("dst_range_err", err, 1);
      rd(36, 11, 12, "alias_intact");
      send(6, 100, 0, 0);
      chk("src_range_err", err, 1);
      chk("src_range_rsp", rsp_valid, 0);
      rd(0, 40'd525063528465, 0, "r0_intact");

      send(5, 0, 1, 2);
      repeat (10) tick();
      chk("mid_mul_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mul_ready", cmd_ready, 1);
      chk("rst_mul_busy", busy, 0);
      rd(2, 0, 0, "rst_r2");
      rd(0, 0, 0, "rst_r0");
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
